// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

  localparam int unsigned DEPTH_DEF = 256;
  localparam int unsigned AW_DEF    = 32;

  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to i_prio.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic [1:0] o_gnt,
  output logic       o_winner
);

  always_comb begin
    o_winner = PORT_MEM;
    if (i_req == 2'b11) begin
      o_winner = i_prio;
    end else if (i_req[1]) begin
      o_winner = PORT_DBG;
    end

    o_gnt = '0;
    if (i_req != 2'b00) begin
      o_gnt[o_winner] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the MEM stage (port 0) and the
// debug/loader port (port 1); one access every three cycles.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [1:0]    req_i,
  input  logic [1:0]    we_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [31:0]   wdata0_i,
  input  logic [31:0]   wdata1_i,
  output logic [1:0]    gnt_o,
  output logic [1:0]    done_o,
  output logic          err_o,
  output logic [31:0]   rdata_o,
  input  logic [31:0]   ReadData_i,
  output logic          MemWrite_o,
  output logic          MemRead_o,
  output logic [AW-1:0] addr_o,
  output logic [31:0]   WriteData_o
);

  // One extra bit so the range compare stays exact for any DEPTH up to 2**AW.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic          r_prio;
  logic          r_owner;
  logic          r_we;
  logic          r_err;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;

  logic [1:0]    w_arb_gnt;
  logic          w_winner;
  logic          w_take;
  logic          w_in_range;

  assign w_in_range  = ({1'b0, r_addr} < DEPTH_W);
  assign addr_o      = r_addr;
  assign WriteData_o = r_wdata;

  rr_arb2 u_arb (
    .i_req    (req_i),
    .i_prio   (r_prio),
    .o_gnt    (w_arb_gnt),
    .o_winner (w_winner)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // gnt_o is combinational from req_i; it is masked while reset is held so
  // every output reads zero during reset.
  always_comb begin
    w_next     = r_state;
    w_take     = 1'b0;
    gnt_o      = '0;
    done_o     = '0;
    err_o      = 1'b0;
    rdata_o    = '0;
    MemWrite_o = 1'b0;
    MemRead_o  = 1'b0;
    case (r_state)
      IDLE: begin
        if ((req_i != 2'b00) && !rst_i) begin
          gnt_o  = w_arb_gnt;
          w_take = 1'b1;
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        MemWrite_o = r_we & w_in_range;
        MemRead_o  = ~r_we & w_in_range;
        w_next     = RESP;
      end
      RESP: begin
        done_o[r_owner] = 1'b1;
        err_o           = r_err;
        rdata_o         = r_rdata;
        w_next          = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prio  <= 1'b0;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_take) begin
        r_owner <= w_winner;
        r_we    <= we_i[w_winner];
        r_addr  <= w_winner ? addr1_i  : addr0_i;
        r_wdata <= w_winner ? wdata1_i : wdata0_i;
        r_prio  <= ~w_winner;
      end
      if (r_state == ISSUE) begin
        r_err   <= ~w_in_range;
        r_rdata <= (~r_we & w_in_range) ? ReadData_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a cycle-timeline model.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_i, we_i;
  logic [31:0] addr0_i, addr1_i, wdata0_i, wdata1_i;
  logic [1:0]  gnt_o, done_o;
  logic        err_o;
  logic [31:0] rdata_o, ReadData_i, addr_o, WriteData_o;
  logic        MemWrite_o, MemRead_o;

  dmem_arbiter #(.DEPTH(256), .AW(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .ReadData_i(ReadData_i), .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o),
    .addr_o(addr_o), .WriteData_o(WriteData_o)
  );

  always #5 clk_i = ~clk_i;

  // Environment: the data memory itself.
  logic [31:0] env_mem [256];
  always @(negedge clk_i) if (MemRead_o) ReadData_i <= env_mem[addr_o[7:0]];
  always @(posedge clk_i) if (MemWrite_o) env_mem[addr_o[7:0]] <= WriteData_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: cycles elapsed since the last grant (0 = free), plus expected memory.
  logic [31:0] ref_mem [256];
  int          m_phase;
  logic        m_prio;
  logic        t_port, t_we;
  logic [31:0] t_addr, t_wdata;
  logic [1:0]  last_gnt;
  int          win_log [$];

  task automatic model_check(input logic [1:0] rq, input logic [1:0] w,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1);
    logic [1:0] e_gnt;
    logic       win, inr;
    e_gnt = 2'b00;
    win   = 1'b0;
    if (m_phase == 0 && rq != 2'b00) begin
      if (rq == 2'b11) win = m_prio;
      else             win = rq[1];
      e_gnt[win] = 1'b1;
    end
    inr = (t_addr < 32'd256);
    chk("gnt", 32'(gnt_o), 32'(e_gnt));
    chk("memwrite", 32'(MemWrite_o), 32'(m_phase == 1 && t_we && inr));
    chk("memread", 32'(MemRead_o), 32'(m_phase == 1 && !t_we && inr));
    chk("strobe_excl", 32'(MemWrite_o & MemRead_o), 32'd0);
    if (m_phase == 1 && inr) chk("addr_o", addr_o, t_addr);
    if (m_phase == 1 && inr && t_we) chk("wdata_o", WriteData_o, t_wdata);
    chk("done", 32'(done_o), (m_phase == 2) ? (32'd1 << t_port) : 32'd0);
    chk("err", 32'(err_o), 32'(m_phase == 2 && !inr));
    chk("rdata", rdata_o, (m_phase == 2 && !t_we && inr) ? ref_mem[t_addr[7:0]] : 32'd0);
    last_gnt = gnt_o;
    case (m_phase)
      0: if (rq != 2'b00) begin
        t_port  = win;
        t_we    = w[win];
        t_addr  = win ? a1 : a0;
        t_wdata = win ? d1 : d0;
        m_prio  = ~win;
        win_log.push_back(int'(win));
        m_phase = 1;
      end
      1: begin
        if (t_we && inr) ref_mem[t_addr[7:0]] = t_wdata;
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic step(input logic [1:0] rq, input logic [1:0] w,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    @(posedge clk_i);
    #1;
    req_i = rq; we_i = w; addr0_i = a0; addr1_i = a1; wdata0_i = d0; wdata1_i = d1;
    @(negedge clk_i);
    model_check(rq, w, a0, a1, d0, d1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_rdata"}, rdata_o, 32'd0);
    chk({tag, "_mw"}, 32'(MemWrite_o), 32'd0);
    chk({tag, "_mr"}, 32'(MemRead_o), 32'd0);
    chk({tag, "_addr"}, addr_o, 32'd0);
    chk({tag, "_wd"}, WriteData_o, 32'd0);
  endtask

  logic        pend [2];
  logic        rwe  [2];
  logic [31:0] ra   [2];
  logic [31:0] rd   [2];

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
      ref_mem[i] = env_mem[i];
    end
    m_phase = 0; m_prio = 1'b0;
    t_port = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0;
    last_gnt = '0; ReadData_i = '0;
    rst_i = 1'b1; req_i = 2'b01; we_i = '0;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    #12;
    chk_all_zero("reset");
    @(posedge clk_i); #1; rst_i = 1'b0; req_i = '0;

    // Tie from reset, both held: expect 0,1,0,1 spaced three cycles apart.
    for (int i = 0; i < 12; i++) step(2'b11, 2'b00, 32'd1, 32'd2, 32'd0, 32'd0);
    chk("tie_count", 32'(win_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < win_log.size(); i++)
      chk("tie_order", 32'(win_log[i]), 32'(i % 2));

    // Port 0 writes then reads back addr 5.
    step(2'b01, 2'b01, 32'd5, 32'd0, 32'hDEAD_BEEF, 32'd0);
    step(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    step(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    step(2'b01, 2'b00, 32'd5, 32'd0, 32'd0, 32'd0);
    step(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    step(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("rd_back5", rdata_o, 32'hDEAD_BEEF);

    // Port 1 reads out of range.
    step(2'b10, 2'b00, 32'd0, 32'd256, 32'd0, 32'd0);
    step(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    step(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("oob_err", 32'(err_o), 32'd1);

    // Reset in the middle of a write ISSUE cycle loses the write.
    step(2'b01, 2'b01, 32'd7, 32'd0, 32'h0000_1234, 32'd0);
    @(posedge clk_i); #1; req_i = '0;
    @(negedge clk_i);
    chk("rst_pre_mw", 32'(MemWrite_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk_all_zero("rst_iss");
    @(posedge clk_i); #1; rst_i = 1'b0;
    m_phase = 0; m_prio = 1'b0;
    step(2'b01, 2'b00, 32'd7, 32'd0, 32'd0, 32'd0);
    step(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    step(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("rst_lost_wr", rdata_o, 32'd7 * 32'h0101_0101 ^ 32'hA5A5_0000);

    // Port 1 pulses req only during RESP: ignored.
    step(2'b01, 2'b00, 32'd3, 32'd0, 32'd0, 32'd0);
    step(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    step(2'b10, 2'b01, 32'd0, 32'd9, 32'd0, 32'hFFFF_FFFF);
    step(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    step(2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("resp_req_mw", 32'(MemWrite_o), 32'd0);

    // Random traffic; requesters hold until granted, occasionally withdraw.
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; rwe[p] = 1'b0; ra[p] = '0; rd[p] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (last_gnt[p]) pend[p] = 1'b0;
        else if (pend[p] && ($urandom % 20 == 0)) pend[p] = 1'b0;
        if (!pend[p] && ($urandom % 3 == 0)) begin
          pend[p] = 1'b1;
          rwe[p]  = 1'($urandom);
          rd[p]   = $urandom;
          case ($urandom % 8)
            0:       ra[p] = 32'd256 + ($urandom % 16);
            1:       ra[p] = $urandom;
            default: ra[p] = $urandom % 256;
          endcase
        end
      end
      step({pend[1], pend[0]}, {rwe[1], rwe[0]}, ra[0], ra[1], rd[0], rd[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
